// File: rtl/fu_mul_pipe_pkg.sv
// fu_mul_pipe_pkg: shared types, multiply opcodes and CDB packing for the pipelined multiplier
package fu_mul_pipe_pkg;
  localparam int MUL_LATENCY_DEFAULT = 3;
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } mul_op_e;
  typedef struct packed {
    logic [31:0] vj;
    logic [31:0] vk;
    logic [2:0]  funct3;
    logic [4:0]  fi;
    logic [4:0]  fj;
    logic [4:0]  fk;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
  } fu_status_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] pc;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } cdb_data_t;
  function automatic cdb_data_t to_cdb(input fu_status_t s, input logic [63:0] p);
    cdb_data_t c;
    c = '0;
    c.valid = 1'b1;
    c.order = s.order;
    c.inst = s.inst;
    c.rd = s.fi;
    c.data = (s.funct3 == MUL) ? p[31:0] : p[63:32];
    c.rs1_addr = s.fj;
    c.rs2_addr = s.fk;
    c.rs1_rdata = s.vj;
    c.rs2_rdata = s.vk;
    c.pc = s.pc;
    c.pc_wdata = s.pc + 32'd4;
    return c;
  endfunction
endpackage

// File: rtl/fu_mul_pipe_if.sv
// fu_mul_pipe_if: issue/complete handshake bundle between scoreboard, multiplier and CDB arbiter
interface fu_mul_pipe_if #(
  parameter int LATENCY = fu_mul_pipe_pkg::MUL_LATENCY_DEFAULT
);
  import fu_mul_pipe_pkg::*;
  logic                               flush;
  logic                               issue_valid;
  logic                               issue_ready;
  fu_status_t                         issue_data;
  logic                               complete_valid;
  logic                               complete_ready;
  cdb_data_t                          complete_data;
  logic                               exec_busy;
  logic [$clog2(LATENCY+1)-1:0]       in_flight;
  modport master (
    output flush, issue_valid, issue_data, complete_ready,
    input  issue_ready, complete_valid, complete_data, exec_busy, in_flight
  );
  modport slave (
    input  flush, issue_valid, issue_data, complete_ready,
    output issue_ready, complete_valid, complete_data, exec_busy, in_flight
  );
endinterface

// File: rtl/fu_mul_pipe_mul_core.sv
// mul_core: combinational 32x32->64 multiply with funct3-selected operand signedness
module mul_core
  import fu_mul_pipe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  output logic [63:0] product
);
  logic        a_signed;
  logic        b_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  always_comb begin
    a_signed = !funct3[2] && funct3 != MULHU;
    b_signed = funct3 == MUL || funct3 == MULH;
    a_ext = {{32{a_signed && a[31]}}, a};
    b_ext = {{32{b_signed && b[31]}}, b};
    product = a_ext * b_ext;
  end
endmodule

// File: rtl/fu_mul_pipe.sv
// fu_mul_pipe: fully pipelined RV32M multiplier unit with CDB backpressure and occupancy report
module fu_mul_pipe
  import fu_mul_pipe_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  fu_mul_pipe_if.slave fu
);
  localparam int CW = $clog2(LATENCY + 1);
  logic [63:0]        product;
  logic [LATENCY-1:0] valid_v;
  fu_status_t         stat_v [LATENCY];
  logic [63:0]        prod_v [LATENCY];
  logic               advance;
  logic               accept;
  mul_core u_core (
    .a      (fu.issue_data.vj),
    .b      (fu.issue_data.vk),
    .funct3 (fu.issue_data.funct3),
    .product(product)
  );
  assign advance = !valid_v[LATENCY-1] || fu.complete_ready;
  assign accept = fu.issue_valid && advance && !fu.flush;
  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic        valid_d, valid_q, in_valid;
    fu_status_t  stat_d, stat_q, in_stat;
    logic [63:0] prod_d, prod_q, in_prod;
    if (i == 0) begin : g_head
      assign in_valid = accept;
      assign in_stat = accept ? fu.issue_data : '0;
      assign in_prod = accept ? product : '0;
    end else begin : g_body
      assign in_valid = valid_v[i-1];
      assign in_stat = stat_v[i-1];
      assign in_prod = prod_v[i-1];
    end
    always_comb begin
      valid_d = fu.flush ? 1'b0 : advance ? in_valid : valid_q;
      stat_d = fu.flush ? '0 : advance ? in_stat : stat_q;
      prod_d = fu.flush ? '0 : advance ? in_prod : prod_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        stat_q <= '0;
        prod_q <= '0;
      end else begin
        valid_q <= valid_d;
        stat_q <= stat_d;
        prod_q <= prod_d;
      end
    end
    assign valid_v[i] = valid_q;
    assign stat_v[i] = stat_q;
    assign prod_v[i] = prod_q;
  end
  assign fu.issue_ready = advance;
  assign fu.complete_valid = valid_v[LATENCY-1];
  assign fu.complete_data = valid_v[LATENCY-1] ? to_cdb(stat_v[LATENCY-1], prod_v[LATENCY-1]) : '0;
  assign fu.exec_busy = |valid_v;
  assign fu.in_flight = CW'($countones(valid_v));
endmodule

// File: tb/tb_fu_mul_pipe.sv
// tb_fu_mul_pipe: randomized and directed self-checking bench for fu_mul_pipe at latencies 1, 3 and 8
module tb_fu_mul_pipe;
  import fu_mul_pipe_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  fu_mul_pipe_if #(.LATENCY(3)) if3 ();
  fu_mul_pipe_if #(.LATENCY(1)) if1 ();
  fu_mul_pipe_if #(.LATENCY(8)) if8 ();
  fu_mul_pipe #(.LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .fu(if3));
  fu_mul_pipe #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .fu(if1));
  fu_mul_pipe #(.LATENCY(8)) u_l8 (.clk(clk), .rst(rst), .fu(if8));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    assert ((!if3.issue_valid || !if3.issue_data.funct3[2]) &&
            (!if1.issue_valid || !if1.issue_data.funct3[2]) &&
            (!if8.issue_valid || !if8.issue_data.funct3[2]))
    else $error("illegal funct3 issued to multiplier");
  end
  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b000, 3'b001: p = sa * sb;
      3'b010:         p = sa * ub;
      default:        p = ua * ub;
    endcase
    return (f == 3'b000) ? p[31:0] : p[63:32];
  endfunction
  function automatic cdb_data_t exp_cdb(input fu_status_t s);
    cdb_data_t c;
    c = '0;
    c.valid = 1'b1;
    c.order = s.order;
    c.inst = s.inst;
    c.rd = s.fi;
    c.data = ref_mul(s.funct3, s.vj, s.vk);
    c.rs1_addr = s.fj;
    c.rs2_addr = s.fk;
    c.rs1_rdata = s.vj;
    c.rs2_rdata = s.vk;
    c.pc = s.pc;
    c.pc_wdata = s.pc + 32'd4;
    return c;
  endfunction
  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction
  function automatic fu_status_t make_stat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    fu_status_t s;
    s.vj = a;
    s.vk = b;
    s.funct3 = f;
    s.fi = 5'($urandom());
    s.fj = 5'($urandom());
    s.fk = 5'($urandom());
    s.pc = $urandom() & 32'hFFFF_FFFC;
    s.inst = $urandom();
    s.order = {$urandom(), $urandom()};
    return s;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic init_ifs();
    if3.flush = 1'b0; if3.issue_valid = 1'b0; if3.issue_data = '0; if3.complete_ready = 1'b1;
    if1.flush = 1'b0; if1.issue_valid = 1'b0; if1.issue_data = '0; if1.complete_ready = 1'b1;
    if8.flush = 1'b0; if8.issue_valid = 1'b0; if8.issue_data = '0; if8.complete_ready = 1'b1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (if3.complete_valid !== 1'b0) begin n_fail++; $display("FAIL reset_complete_valid got=%b want=0", if3.complete_valid); end
    n_checks++;
    if (if3.complete_data !== '0) begin n_fail++; $display("FAIL reset_complete_data got=%h want=0", if3.complete_data); end
    n_checks++;
    if (if3.exec_busy !== 1'b0) begin n_fail++; $display("FAIL reset_exec_busy got=%b want=0", if3.exec_busy); end
    n_checks++;
    if (if3.in_flight !== 2'd0) begin n_fail++; $display("FAIL reset_in_flight got=%0d want=0", if3.in_flight); end
    n_checks++;
    if (if3.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got=%b want=1", if3.issue_ready); end
    step();
  endtask
  task automatic run_one(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    fu_status_t s;
    cdb_data_t exp;
    s = make_stat(f, a, b);
    exp = exp_cdb(s);
    if3.issue_data = s;
    if3.issue_valid = 1'b1;
    if3.complete_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if3.issue_ready !== 1'b1) begin n_fail++; $display("FAIL %s_issue_ready got=%b want=1", name, if3.issue_ready); end
    step();
    if3.issue_valid = 1'b0;
    if3.issue_data = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        n_checks++;
        if (if3.complete_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid cycle=%0d got=%b want=0", name, k, if3.complete_valid); end
      end else begin
        n_checks++;
        if (if3.complete_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got=%b want=1", name, if3.complete_valid); end
        n_checks++;
        if (if3.complete_data.data !== want) begin n_fail++; $display("FAIL %s_data got=%h want=%h", name, if3.complete_data.data, want); end
        n_checks++;
        if (if3.complete_data !== exp) begin n_fail++; $display("FAIL %s_cdb got=%h want=%h", name, if3.complete_data, exp); end
      end
      step();
    end
  endtask
  task automatic test_directed();
    run_one("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_one("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_one("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_one("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
  endtask
  task automatic test_back_to_back();
    fu_status_t items [5];
    fu_status_t q [$];
    fu_status_t front;
    int idx, got, peak;
    idx = 0;
    got = 0;
    peak = 0;
    for (int i = 0; i < 5; i++) items[i] = make_stat(3'($urandom_range(0, 3)), rand_op(), rand_op());
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if3.issue_valid = idx < 5;
      if3.issue_data = (idx < 5) ? items[idx] : '0;
      if3.complete_ready = !(cyc >= 3 && cyc < 7);
      @(negedge clk);
      if (cyc == 3) begin
        n_checks++;
        if (if3.complete_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got=%b want=1", if3.complete_valid); end
      end
      if (cyc >= 3 && cyc < 7) begin
        n_checks++;
        if (if3.issue_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_issue_ready cycle=%0d got=%b want=0", cyc, if3.issue_ready); end
        n_checks++;
        if (if3.complete_data !== exp_cdb(items[0])) begin n_fail++; $display("FAIL b2b_stall_hold cycle=%0d got=%h want=%h", cyc, if3.complete_data, exp_cdb(items[0])); end
        n_checks++;
        if (if3.in_flight !== 2'd3) begin n_fail++; $display("FAIL b2b_stall_in_flight cycle=%0d got=%0d want=3", cyc, if3.in_flight); end
      end
      if (cyc == 8) begin
        n_checks++;
        if (if3.in_flight !== 2'd3) begin n_fail++; $display("FAIL b2b_swap_in_flight got=%0d want=3", if3.in_flight); end
      end
      if (int'(if3.in_flight) > peak) peak = int'(if3.in_flight);
      if (if3.issue_valid && if3.issue_ready) begin
        q.push_back(items[idx]);
        idx++;
      end
      if (if3.complete_valid && if3.complete_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_result got=%h want=none", if3.complete_data);
        end else begin
          front = q.pop_front();
          if (if3.complete_data !== exp_cdb(front)) begin n_fail++; $display("FAIL b2b_order got=%h want=%h", if3.complete_data, exp_cdb(front)); end
        end
        got++;
      end
      step();
    end
    if3.issue_valid = 1'b0;
    if3.issue_data = '0;
    if3.complete_ready = 1'b1;
    n_checks++;
    if (got !== 5) begin n_fail++; $display("FAIL b2b_count got=%0d want=5", got); end
    n_checks++;
    if (peak !== 3) begin n_fail++; $display("FAIL b2b_peak got=%0d want=3", peak); end
  endtask
  task automatic test_flush();
    fu_status_t items [4];
    for (int i = 0; i < 4; i++) items[i] = make_stat(3'($urandom_range(0, 3)), rand_op(), rand_op());
    for (int cyc = 0; cyc < 4; cyc++) begin
      if3.issue_valid = 1'b1;
      if3.issue_data = items[cyc];
      if3.complete_ready = 1'b1;
      if3.flush = cyc == 3;
      @(negedge clk);
      if (cyc == 3) begin
        n_checks++;
        if (if3.in_flight !== 2'd3) begin n_fail++; $display("FAIL flush_pre_in_flight got=%0d want=3", if3.in_flight); end
        n_checks++;
        if (if3.complete_data !== exp_cdb(items[0])) begin n_fail++; $display("FAIL flush_same_cycle_output got=%h want=%h", if3.complete_data, exp_cdb(items[0])); end
      end
      step();
    end
    if3.flush = 1'b0;
    if3.issue_valid = 1'b0;
    if3.issue_data = '0;
    for (int cyc = 4; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin
        n_checks++;
        if (if3.in_flight !== 2'd0) begin n_fail++; $display("FAIL flush_in_flight got=%0d want=0", if3.in_flight); end
        n_checks++;
        if (if3.exec_busy !== 1'b0) begin n_fail++; $display("FAIL flush_exec_busy got=%b want=0", if3.exec_busy); end
      end
      n_checks++;
      if (if3.complete_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak cycle=%0d got=%b want=0", cyc, if3.complete_valid); end
      step();
    end
  endtask
  task automatic test_rst_mid();
    fu_status_t s;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if3.issue_valid = 1'b1;
      if3.issue_data = make_stat(3'($urandom_range(0, 3)), rand_op(), rand_op());
      rst = cyc == 2;
      step();
    end
    rst = 1'b0;
    if3.issue_valid = 1'b0;
    if3.issue_data = '0;
    @(negedge clk);
    n_checks++;
    if (if3.complete_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_complete_valid got=%b want=0", if3.complete_valid); end
    n_checks++;
    if (if3.complete_data !== '0) begin n_fail++; $display("FAIL rst_mid_complete_data got=%h want=0", if3.complete_data); end
    n_checks++;
    if (if3.exec_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_exec_busy got=%b want=0", if3.exec_busy); end
    n_checks++;
    if (if3.in_flight !== 2'd0) begin n_fail++; $display("FAIL rst_mid_in_flight got=%0d want=0", if3.in_flight); end
    n_checks++;
    if (if3.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_issue_ready got=%b want=1", if3.issue_ready); end
    step();
    step();
    s = make_stat(3'($urandom_range(0, 3)), rand_op(), rand_op());
    if3.issue_valid = 1'b1;
    if3.issue_data = s;
    step();
    if3.issue_valid = 1'b0;
    if3.issue_data = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (if3.complete_valid !== (k == 3)) begin n_fail++; $display("FAIL rst_mid_reissue_valid cycle=%0d got=%b want=%b", k, if3.complete_valid, k == 3); end
      if (k == 3) begin
        n_checks++;
        if (if3.complete_data !== exp_cdb(s)) begin n_fail++; $display("FAIL rst_mid_reissue_data got=%h want=%h", if3.complete_data, exp_cdb(s)); end
      end
      step();
    end
  endtask
  task automatic test_sweep();
    localparam int N = 24;
    fu_status_t items [N];
    cdb_data_t want;
    logic exp_v;
    for (int i = 0; i < N; i++) items[i] = make_stat(3'($urandom_range(0, 3)), rand_op(), rand_op());
    for (int t = 0; t < N + 10; t++) begin
      if3.issue_valid = t < N; if3.issue_data = (t < N) ? items[t] : '0; if3.complete_ready = 1'b1;
      if1.issue_valid = t < N; if1.issue_data = (t < N) ? items[t] : '0; if1.complete_ready = 1'b1;
      if8.issue_valid = t < N; if8.issue_data = (t < N) ? items[t] : '0; if8.complete_ready = 1'b1;
      @(negedge clk);
      exp_v = t >= 1 && t - 1 < N;
      want = exp_v ? exp_cdb(items[exp_v ? t - 1 : 0]) : '0;
      n_checks++;
      if (if1.complete_valid !== exp_v || if1.complete_data !== want) begin n_fail++; $display("FAIL sweep_l1 cycle=%0d got=%b/%h want=%b/%h", t, if1.complete_valid, if1.complete_data.data, exp_v, want.data); end
      exp_v = t >= 3 && t - 3 < N;
      want = exp_v ? exp_cdb(items[exp_v ? t - 3 : 0]) : '0;
      n_checks++;
      if (if3.complete_valid !== exp_v || if3.complete_data !== want) begin n_fail++; $display("FAIL sweep_l3 cycle=%0d got=%b/%h want=%b/%h", t, if3.complete_valid, if3.complete_data.data, exp_v, want.data); end
      exp_v = t >= 8 && t - 8 < N;
      want = exp_v ? exp_cdb(items[exp_v ? t - 8 : 0]) : '0;
      n_checks++;
      if (if8.complete_valid !== exp_v || if8.complete_data !== want) begin n_fail++; $display("FAIL sweep_l8 cycle=%0d got=%b/%h want=%b/%h", t, if8.complete_valid, if8.complete_data.data, exp_v, want.data); end
      n_checks++;
      if (if1.issue_ready !== 1'b1 || if8.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_issue_ready cycle=%0d got=%b%b want=11", t, if1.issue_ready, if8.issue_ready); end
      step();
    end
    init_ifs();
  endtask
  initial begin
    rst = 1'b1;
    init_ifs();
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
